// File: rtl/decode_sequencer.sv
// rtl/decode_sequencer.sv - instruction decode merged with FETCH/EXEC1/EXEC2/HALT phase sequencer
//
// Parameters:
//   SDEPTH     hardware stack depth in words; stack_depth is SW = clog2(SDEPTH+1) bits
//   RESET_RUN  1: leave reset into S_FETCH, 0: leave reset into S_HALT
// Optional build macro:
//   STACK_GUARD_EN  traps PSH/CLL on a full stack and POP/RTN on an empty one:
//                   suppresses the access and all register writes, sets sticky
//                   stack_fault and halts. Undefined: stack_fault is tied 0.
// Ports:
//   CLK, nRESET                  clock (rising edge), asynchronous active-low reset
//   instr, instr_valid           instruction word from RAMi, sampled in S_FETCH
//   mem_ready                    data RAM / stack access complete
//   COND_result                  JCX condition
//   run                          resume pulse, acted on only in S_HALT
//   FETCH, EXEC1, EXEC2, halted  one-hot phase / halt flags
//   R_en, R0_count               register write enables (bit n = Rn), PC increment
//   s1..s5, ALU_en               register-file selects and datapath muxing
//   RAMi_en, RAMd_en, RAMd_wren  memory controls
//   stack_en, stack_rw, stack_rst, stack_depth, stack_fault  stack controls/status
module decode_sequencer #(
    parameter int SDEPTH    = 16,
    parameter int RESET_RUN = 0,
    localparam int SW       = $clog2(SDEPTH + 1)
) (
    input  logic          CLK,
    input  logic          nRESET,
    input  logic [15:0]   instr,
    input  logic          instr_valid,
    input  logic          mem_ready,
    input  logic          COND_result,
    input  logic          run,
    output logic          FETCH,
    output logic          EXEC1,
    output logic          EXEC2,
    output logic          halted,
    output logic [7:0]    R_en,
    output logic          R0_count,
    output logic [2:0]    s1,
    output logic [2:0]    s2,
    output logic [2:0]    s3,
    output logic          s4,
    output logic          s5,
    output logic          ALU_en,
    output logic          RAMi_en,
    output logic          RAMd_en,
    output logic          RAMd_wren,
    output logic          stack_en,
    output logic          stack_rw,
    output logic          stack_rst,
    output logic [SW-1:0] stack_depth,
    output logic          stack_fault
);

    typedef enum logic [1:0] {S_HALT, S_FETCH, S_EXEC1, S_EXEC2} state_t;

    localparam logic [SW-1:0] DEPTH_MAX = SW'(SDEPTH);

    state_t        state, state_nxt;
    logic [15:0]   ir;
    logic [SW-1:0] depth;

    // ISA fields
    logic [5:0] op;
    logic [2:0] rls, rd, rs1, rs2;
    logic       lo;

    assign op  = ir[14:9];
    assign rls = ir[13:11];
    assign rd  = ir[8:6];
    assign rs1 = ir[5:3];
    assign rs2 = ir[2:0];
    assign lo  = ~ir[15];

    logic is_lda, is_sta, is_jmp, is_jma, is_jcx, is_mul, is_mla, is_mls;
    logic is_cll, is_rtn, is_psh, is_pop, is_ldr, is_str, is_nop, is_stp, is_alu;

    assign is_lda = ir[15] & ~ir[14];
    assign is_sta = ir[15] &  ir[14];
    assign is_jmp = lo & (op == 6'b000000);
    assign is_jma = lo & (op == 6'b000001);
    assign is_jcx = lo & (op[5:4] == 2'b00) & ((op[3:2] == 2'b01) | (op[3:2] == 2'b10));
    assign is_mul = lo & (op == 6'b011100);
    assign is_mla = lo & (op == 6'b011101);
    assign is_mls = lo & (op == 6'b011110);
    assign is_cll = lo & (op == 6'b100110);
    assign is_rtn = lo & (op == 6'b100111);
    assign is_psh = lo & (op == 6'b101000);
    assign is_pop = lo & (op == 6'b101001);
    assign is_ldr = lo & (op == 6'b101010);
    assign is_str = lo & (op == 6'b101011);
    assign is_nop = lo & (op == 6'b111110);
    assign is_stp = lo & (op == 6'b111111);
    assign is_alu = lo & ~(is_jmp | is_jma | is_jcx | is_mul | is_mla | is_mls | is_cll |
                           is_rtn | is_psh | is_pop | is_ldr | is_str | is_nop | is_stp);

    logic is_push, is_pop_any, is_mem, needs_exec2, jump_taken;

    assign is_push     = is_psh | is_cll;
    assign is_pop_any  = is_pop | is_rtn;
    assign is_mem      = is_lda | is_sta | is_ldr | is_str | is_push | is_pop_any;
    assign needs_exec2 = is_lda | is_mul | is_mla | is_mls | is_pop | is_ldr | is_rtn;
    assign jump_taken  = is_jmp | is_jma | (is_jcx & COND_result);

    // A trapped stack op never reaches the stack, so it completes without mem_ready.
    logic stack_err;
    logic e1_done;

    assign e1_done = (state == S_EXEC1) & (~is_mem | mem_ready | stack_err);

`ifdef STACK_GUARD_EN
    logic fault_q;

    assign stack_err = (is_push & (depth == DEPTH_MAX)) | (is_pop_any & (depth == '0));

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            fault_q <= 1'b0;
        end else if (e1_done && stack_err) begin
            fault_q <= 1'b1;
        end
    end

    assign stack_fault = fault_q;
`else
    assign stack_err   = 1'b0;
    assign stack_fault = 1'b0;
`endif

    // Selects depend only on the latched instruction.
    assign s1     = is_sta ? rls :
                    (is_jmp | is_jma | is_lda | is_nop | is_stp | is_pop | is_cll | is_rtn) ? 3'd0 : rs1;
    assign s2     = (is_alu | is_jcx | is_mul | is_mla | is_mls) ? rs2 : 3'd0;
    assign s3     = (is_sta | is_lda | is_nop | is_stp | is_psh | is_pop | is_rtn) ? 3'd0 : rd;
    assign s4     = ~(is_lda | is_ldr);
    assign ALU_en = is_lda | is_sta;

    assign stack_depth = depth;

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state <= (RESET_RUN != 0) ? S_FETCH : S_HALT;
            ir    <= '0;
            depth <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_FETCH && instr_valid) begin
                ir <= instr;
            end
            if (e1_done && !stack_err) begin
                if (is_stp) begin
                    depth <= '0;
                end else if (is_push && depth != DEPTH_MAX) begin
                    depth <= depth + SW'(1);
                end else if (is_pop_any && depth != '0) begin
                    depth <= depth - SW'(1);
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        FETCH     = 1'b0;
        EXEC1     = 1'b0;
        EXEC2     = 1'b0;
        halted    = 1'b0;
        RAMi_en   = 1'b0;
        RAMd_en   = 1'b0;
        RAMd_wren = 1'b0;
        stack_en  = 1'b0;
        stack_rw  = 1'b0;
        stack_rst = 1'b0;
        s5        = 1'b0;
        R_en      = 8'h00;
        R0_count  = 1'b0;
        case (state)
            S_HALT: begin
                halted = 1'b1;
                if (run) begin
                    state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                FETCH   = 1'b1;
                RAMi_en = 1'b1;
                if (instr_valid) begin
                    state_nxt = S_EXEC1;
                end
            end
            S_EXEC1: begin
                // Access strobes are held across the whole mem_ready wait;
                // register writes and PC increment fire only on the last cycle.
                EXEC1     = 1'b1;
                RAMd_en   = is_lda | is_sta | is_ldr | is_str;
                RAMd_wren = is_sta | is_str;
                stack_en  = (is_push | is_pop_any) & ~stack_err;
                stack_rw  = is_push;
                stack_rst = is_stp;
                s5        = is_ldr | is_str;
                if (e1_done) begin
                    if (!stack_err) begin
                        if (is_alu) begin
                            R_en[rd] = 1'b1;
                        end
                        if (jump_taken | is_cll) begin
                            R_en[0] = 1'b1;
                        end
                        R0_count = ~(jump_taken | is_cll | is_rtn | is_stp);
                    end
                    if (is_stp | stack_err) begin
                        state_nxt = S_HALT;
                    end else if (needs_exec2) begin
                        state_nxt = S_EXEC2;
                    end else begin
                        state_nxt = S_FETCH;
                    end
                end
            end
            S_EXEC2: begin
                EXEC2 = 1'b1;
                if (is_lda) begin
                    R_en[rls] = 1'b1;
                end
                if (is_mul | is_mla | is_mls | is_pop | is_ldr) begin
                    R_en[rd] = 1'b1;
                end
                if (is_rtn) begin
                    R_en[0] = 1'b1;
                end
                state_nxt = S_FETCH;
            end
            default: state_nxt = S_HALT;
        endcase
    end

endmodule

// File: tb/tb_decode_sequencer.sv
// tb/tb_decode_sequencer.sv - self-checking bench for decode_sequencer
module tb_decode_sequencer;

    localparam int SD = 2;
`ifdef STACK_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        CLK;
    logic        nRESET;
    logic [15:0] instr;
    logic        instr_valid, mem_ready, COND_result, run;
    logic        FETCH, EXEC1, EXEC2, halted;
    logic [7:0]  R_en;
    logic        R0_count;
    logic [2:0]  s1, s2, s3;
    logic        s4, s5, ALU_en, RAMi_en, RAMd_en, RAMd_wren;
    logic        stack_en, stack_rw, stack_rst, stack_fault;
    logic [1:0]  stack_depth;

    int total = 0;
    int bad   = 0;

    int m_depth = 0;
    bit m_fault = 1'b0;

    decode_sequencer #(.SDEPTH(SD), .RESET_RUN(0)) dut (
        .CLK(CLK), .nRESET(nRESET), .instr(instr), .instr_valid(instr_valid),
        .mem_ready(mem_ready), .COND_result(COND_result), .run(run),
        .FETCH(FETCH), .EXEC1(EXEC1), .EXEC2(EXEC2), .halted(halted),
        .R_en(R_en), .R0_count(R0_count), .s1(s1), .s2(s2), .s3(s3),
        .s4(s4), .s5(s5), .ALU_en(ALU_en), .RAMi_en(RAMi_en), .RAMd_en(RAMd_en),
        .RAMd_wren(RAMd_wren), .stack_en(stack_en), .stack_rw(stack_rw),
        .stack_rst(stack_rst), .stack_depth(stack_depth), .stack_fault(stack_fault)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    typedef enum int {K_LDA, K_STA, K_JMP, K_JMA, K_JCX, K_MUL, K_MLA, K_MLS, K_CLL,
                      K_RTN, K_PSH, K_POP, K_LDR, K_STR, K_NOP, K_STP, K_ALU} kind_t;

    function automatic kind_t classify(input logic [15:0] w);
        if (w[15]) return w[14] ? K_STA : K_LDA;
        case (w[14:9])
            6'd0:  return K_JMP;
            6'd1:  return K_JMA;
            6'd4, 6'd5, 6'd6, 6'd7, 6'd8, 6'd9, 6'd10, 6'd11: return K_JCX;
            6'd28: return K_MUL;
            6'd29: return K_MLA;
            6'd30: return K_MLS;
            6'd38: return K_CLL;
            6'd39: return K_RTN;
            6'd40: return K_PSH;
            6'd41: return K_POP;
            6'd42: return K_LDR;
            6'd43: return K_STR;
            6'd62: return K_NOP;
            6'd63: return K_STP;
            default: return K_ALU;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #2;
    endtask

    task automatic resume();
        run = 1'b1;
        #1;
        chk("resume_halted", halted, 1);
        step();
        run = 1'b0;
    endtask

    task automatic do_instr(input logic [15:0] ins, input bit cond, input int delay);
        kind_t      k;
        logic [2:0] rd, rls, rs1, rs2, e1, e2, e3;
        logic [7:0] r1, r2;
        bit         push, pop, memop, flt, taken, ex2, cnt1, halt_after;
        int         nd, n, waits;

        k     = classify(ins);
        rd    = ins[8:6];
        rls   = ins[13:11];
        rs1   = ins[5:3];
        rs2   = ins[2:0];
        push  = (k == K_PSH) || (k == K_CLL);
        pop   = (k == K_POP) || (k == K_RTN);
        memop = (k inside {K_LDA, K_STA, K_LDR, K_STR}) || push || pop;
        flt   = GUARD && ((push && m_depth == SD) || (pop && m_depth == 0));
        taken = (k == K_JMP) || (k == K_JMA) || (k == K_JCX && cond);
        e1    = (k == K_STA) ? rls :
                (k inside {K_JMP, K_JMA, K_LDA, K_NOP, K_STP, K_POP, K_CLL, K_RTN}) ? 3'd0 : rs1;
        e2    = (k inside {K_ALU, K_JCX, K_MUL, K_MLA, K_MLS}) ? rs2 : 3'd0;
        e3    = (k inside {K_STA, K_LDA, K_NOP, K_STP, K_PSH, K_POP, K_RTN}) ? 3'd0 : rd;
        r1    = 8'h00;
        if (!flt && k == K_ALU) r1 = 8'h01 << rd;
        if (!flt && (taken || k == K_CLL)) r1 = r1 | 8'h01;
        cnt1  = !flt && !(taken || k == K_CLL || k == K_RTN || k == K_STP);
        ex2   = !flt && (k inside {K_LDA, K_MUL, K_MLA, K_MLS, K_POP, K_LDR, K_RTN});
        r2    = (k == K_LDA) ? (8'h01 << rls) : (k == K_RTN) ? 8'h01 : (8'h01 << rd);
        halt_after = flt || (k == K_STP);
        if (k == K_STP) nd = 0;
        else if (push) nd = (m_depth < SD) ? m_depth + 1 : SD;
        else if (pop) nd = (m_depth > 0) ? m_depth - 1 : 0;
        else nd = m_depth;

        waits = $urandom_range(0, 1);
        for (int i = 0; i <= waits; i++) begin
            instr_valid = (i == waits);
            instr       = (i == waits) ? ins : 16'($urandom);
            mem_ready   = 1'($urandom);
            run         = 1'b0;
            #1;
            chk("fetch_flag", FETCH, 1);
            chk("fetch_rami", RAMi_en, 1);
            chk("fetch_ren", R_en, 0);
            chk("fetch_halted", halted, 0);
            step();
        end

        n = (memop && !flt) ? delay : 0;
        for (int i = 0; i <= n; i++) begin
            instr_valid = 1'($urandom);
            instr       = 16'($urandom);
            run         = 1'($urandom);
            COND_result = cond;
            mem_ready   = (i < n) ? 1'b0 : ((memop && !flt) ? 1'b1 : 1'($urandom));
            #1;
            chk("e1_flag", EXEC1, 1);
            chk("e1_ramd_en", RAMd_en, (k inside {K_LDA, K_STA, K_LDR, K_STR}));
            chk("e1_ramd_wren", RAMd_wren, (k inside {K_STA, K_STR}));
            chk("e1_stack_en", stack_en, (push || pop) && !flt);
            chk("e1_stack_rw", stack_rw, push);
            chk("e1_stack_rst", stack_rst, k == K_STP);
            chk("e1_s1", s1, e1);
            chk("e1_s2", s2, e2);
            chk("e1_s3", s3, e3);
            chk("e1_s4", s4, !(k == K_LDA || k == K_LDR));
            chk("e1_s5", s5, (k == K_LDR || k == K_STR));
            chk("e1_alu_en", ALU_en, (k == K_LDA || k == K_STA));
            chk("e1_ren", R_en, (i == n) ? r1 : 8'h00);
            chk("e1_r0count", R0_count, (i == n) ? cnt1 : 1'b0);
            chk("e1_depth", stack_depth, m_depth);
            chk("e1_fault", stack_fault, m_fault);
            step();
        end
        m_depth = nd;
        m_fault = m_fault | flt;
        run     = 1'b0;

        if (ex2) begin
            instr_valid = 1'($urandom);
            #1;
            chk("e2_flag", EXEC2, 1);
            chk("e2_ren", R_en, r2);
            chk("e2_r0count", R0_count, 0);
            chk("e2_s5", s5, 0);
            chk("e2_ramd_en", RAMd_en, 0);
            chk("e2_stack_en", stack_en, 0);
            chk("e2_depth", stack_depth, m_depth);
            step();
        end

        if (halt_after) begin
            for (int i = 0; i < 2; i++) begin
                instr_valid = 1'b1;
                #1;
                chk("halt_flag", halted, 1);
                chk("halt_fetch", FETCH, 0);
                chk("halt_rami", RAMi_en, 0);
                chk("halt_depth", stack_depth, m_depth);
                chk("halt_fault", stack_fault, m_fault);
                step();
            end
            resume();
        end
    endtask

    logic [15:0] w;

    initial begin
        nRESET      = 1'b0;
        instr       = 16'h0000;
        instr_valid = 1'b0;
        mem_ready   = 1'b0;
        COND_result = 1'b0;
        run         = 1'b0;
        #1;
        chk("rst_halted", halted, 1);
        chk("rst_fetch", FETCH, 0);
        chk("rst_exec1", EXEC1, 0);
        chk("rst_ren", R_en, 0);
        chk("rst_r0count", R0_count, 0);
        chk("rst_rami", RAMi_en, 0);
        chk("rst_depth", stack_depth, 0);
        chk("rst_fault", stack_fault, 0);
        step();
        step();
        nRESET      = 1'b1;
        instr_valid = 1'b1;
        step();
        #1;
        chk("idle_halted", halted, 1);
        chk("idle_nofetch", FETCH, 0);
        resume();

        do_instr(16'h21D1, 1'b0, 0);
        do_instr(16'h9805, 1'b0, 3);
        do_instr(16'h0815, 1'b1, 0);
        do_instr(16'h0815, 1'b0, 0);
        do_instr(16'h5000, 1'b0, 1);
        do_instr(16'h5000, 1'b0, 0);
        do_instr(16'h5000, 1'b0, 2);
        do_instr(16'h4C00, 1'b0, 1);
        do_instr(16'h5200, 1'b0, 0);
        do_instr(16'h5200, 1'b0, 2);
        do_instr(16'h4E00, 1'b0, 1);
        do_instr(16'h5200, 1'b0, 0);
        do_instr(16'hC4A3, 1'b0, 2);
        do_instr(16'h55EA, 1'b0, 1);
        do_instr(16'h5000, 1'b0, 0);
        do_instr(16'h7E00, 1'b0, 0);
        chk("stp_depth_clear", stack_depth, 0);

        for (int t = 0; t < 250; t++) begin
            w = 16'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                w[15] = 1'b0;
                case ($urandom_range(0, 6))
                    0: w[14:9] = 6'd40;
                    1: w[14:9] = 6'd41;
                    2: w[14:9] = 6'd38;
                    3: w[14:9] = 6'd39;
                    4: w[14:9] = 6'(28 + $urandom_range(0, 2));
                    5: w[14:9] = 6'(42 + $urandom_range(0, 1));
                    default: w[14:9] = 6'($urandom_range(0, 11));
                endcase
            end
            do_instr(w, 1'($urandom), $urandom_range(0, 3));
        end

        if (m_depth == SD) do_instr(16'h5200, 1'b0, 0);
        if (m_depth == 0) do_instr(16'h5000, 1'b0, 0);
        instr_valid = 1'b1;
        instr       = 16'h9805;
        mem_ready   = 1'b0;
        #1;
        chk("abort_fetch", FETCH, 1);
        step();
        #1;
        chk("abort_pre_ramd", RAMd_en, 1);
        chk("abort_pre_depth", stack_depth, m_depth);
        nRESET = 1'b0;
        #1;
        chk("abort_ramd", RAMd_en, 0);
        chk("abort_exec1", EXEC1, 0);
        chk("abort_ren", R_en, 0);
        chk("abort_r0count", R0_count, 0);
        chk("abort_depth", stack_depth, 0);
        chk("abort_fault", stack_fault, 0);
        chk("abort_halted", halted, 1);
        m_depth = 0;
        m_fault = 1'b0;
        step();
        nRESET    = 1'b1;
        mem_ready = 1'b1;
        step();
        #1;
        chk("post_abort_halted", halted, 1);
        chk("post_abort_ren", R_en, 0);
        resume();
        do_instr(16'h21D1, 1'b0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
